// File: rtl/des_seq_pkg.sv
// Shared types and constants for the DES block sequencer.
package des_seq_pkg;

  localparam int ROUNDS  = 16;
  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD0   = 3'd1,
    ST_RD1   = 3'd2,
    ST_RD2   = 3'd3,
    ST_ROUND = 3'd4,
    ST_WR0   = 3'd5,
    ST_WR1   = 3'd6,
    ST_DONE  = 3'd7
  } seq_state_e;

endpackage

// File: rtl/des_cbc_chain.sv
// CBC chaining: holds the chain value and applies the mode-dependent
// pre-XOR (encrypt) and post-XOR (decrypt) around the DES core.
module des_cbc_chain
  import des_seq_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic [BLOCK_W-1:0] i_iv,
  input  logic               i_cbc,
  input  logic               i_decrypt,
  input  logic               i_form,
  input  logic [BLOCK_W-1:0] i_blk_in,
  output logic [BLOCK_W-1:0] o_des_in,
  input  logic               i_update,
  input  logic [BLOCK_W-1:0] i_des_out,
  output logic [BLOCK_W-1:0] o_result
);

  logic [BLOCK_W-1:0] r_chain;
  logic [BLOCK_W-1:0] r_raw;
  logic [BLOCK_W-1:0] w_pre;
  logic [BLOCK_W-1:0] w_post;

  // Pre-XOR only for CBC encrypt, post-XOR only for CBC decrypt.
  always_comb begin
    w_pre  = i_blk_in;
    w_post = i_des_out;
    if (i_cbc && !i_decrypt) begin
      w_pre = i_blk_in ^ r_chain;
    end else begin
      w_pre = i_blk_in;
    end
    if (i_cbc && i_decrypt) begin
      w_post = i_des_out ^ r_chain;
    end else begin
      w_post = i_des_out;
    end
  end

  // Chain register: iv at run start; afterwards the ciphertext of the block
  // just finished (the result when encrypting, the raw input when decrypting).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= '0;
      r_raw   <= '0;
    end else begin
      if (i_load) begin
        r_chain <= i_iv;
      end else if (i_update && i_cbc) begin
        r_chain <= i_decrypt ? r_raw : w_post;
      end
      if (i_form) begin
        r_raw <= i_blk_in;
      end
    end
  end

  assign o_des_in = w_pre;
  assign o_result = w_post;

endmodule

// File: rtl/des_block_seq.sv
// Block sequencer: reads 64-bit blocks from the input RAM, steps the external
// DES core for 16 rounds per block, and writes results to the output RAM.
module des_block_seq
  import des_seq_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int MAX_BLK_W = ADDR_W
)(
  input  logic                 clk1,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 decrypt,
  input  logic                 cbc,
  input  logic [BLOCK_W-1:0]   iv,
  input  logic [MAX_BLK_W-1:0] block_count,
  output logic                 busy,
  output logic                 done,
  output logic [MAX_BLK_W-1:0] blocks_done,
  output logic [ADDR_W-1:0]    ram_in_addr,
  input  logic [WORD_W-1:0]    ram_in_dout,
  output logic [ADDR_W-1:0]    ram_out_addr,
  output logic [WORD_W-1:0]    ram_out_din,
  output logic                 ram_out_we,
  output logic [BLOCK_W-1:0]   des_in,
  output logic [3:0]           des_round_sel,
  output logic                 des_decrypt,
  input  logic [BLOCK_W-1:0]   des_out
);

  localparam int CAP   = 2 ** (ADDR_W - 1);
  localparam int BLK_W = ADDR_W - 1;

  // Requested counts beyond RAM capacity clamp to capacity, so addresses never wrap.
  function automatic logic [ADDR_W-1:0] eff_count(input logic [MAX_BLK_W-1:0] bc);
    if (32'(bc) > 32'(CAP)) begin
      return ADDR_W'(CAP);
    end else begin
      return ADDR_W'(bc);
    end
  endfunction

  seq_state_e           r_state;
  seq_state_e           w_state_nxt;
  logic [BLK_W-1:0]     r_blk;
  logic [BLK_W-1:0]     w_blk_nxt;
  logic [ADDR_W-1:0]    r_count;
  logic                 r_decrypt;
  logic                 r_cbc;
  logic [WORD_W-1:0]    r_lo;
  logic [WORD_W-1:0]    r_result_hi;
  logic                 r_busy;
  logic                 r_done;
  logic [MAX_BLK_W-1:0] r_blocks_done;
  logic [ADDR_W-1:0]    r_in_addr;
  logic [ADDR_W-1:0]    r_out_addr;
  logic [WORD_W-1:0]    r_out_din;
  logic                 r_we;
  logic [BLOCK_W-1:0]   r_des_in;
  logic [3:0]           r_round;
  logic                 w_launch;
  logic                 w_form;
  logic                 w_capture;
  logic                 w_last;
  logic [BLOCK_W-1:0]   w_pre;
  logic [BLOCK_W-1:0]   w_result;

  assign w_last    = (ADDR_W'({1'b0, r_blk}) + ADDR_W'(1)) == r_count;
  assign w_launch  = (r_state == ST_IDLE)  && (w_state_nxt != ST_IDLE);
  assign w_form    = (r_state == ST_RD2)   && (w_state_nxt == ST_ROUND);
  assign w_capture = (r_state == ST_ROUND) && (w_state_nxt == ST_WR0);

  // Next-state logic; abort overrides everything outside IDLE, including start.
  always_comb begin
    w_state_nxt = r_state;
    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            w_state_nxt = (eff_count(block_count) == ADDR_W'(0)) ? ST_DONE : ST_RD0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_RD0:   w_state_nxt = ST_RD1;
        ST_RD1:   w_state_nxt = ST_RD2;
        ST_RD2:   w_state_nxt = ST_ROUND;
        ST_ROUND: w_state_nxt = (r_round == 4'(ROUNDS - 1)) ? ST_WR0 : ST_ROUND;
        ST_WR0:   w_state_nxt = ST_WR1;
        ST_WR1:   w_state_nxt = w_last ? ST_DONE : ST_RD0;
        ST_DONE:  w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Block index: cleared at launch, advanced when WR1 hands over to the next block.
  always_comb begin
    w_blk_nxt = r_blk;
    if (w_launch) begin
      w_blk_nxt = '0;
    end else if ((r_state == ST_WR1) && (w_state_nxt == ST_RD0)) begin
      w_blk_nxt = r_blk + BLK_W'(1);
    end else begin
      w_blk_nxt = r_blk;
    end
  end

  // State, datapath and registered outputs, all derived from the next state
  // so that each output is valid in the cycle of the state it belongs to.
  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_blk         <= '0;
      r_count       <= '0;
      r_decrypt     <= 1'b0;
      r_cbc         <= 1'b0;
      r_lo          <= '0;
      r_result_hi   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_blocks_done <= '0;
      r_in_addr     <= '0;
      r_out_addr    <= '0;
      r_out_din     <= '0;
      r_we          <= 1'b0;
      r_des_in      <= '0;
      r_round       <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_blk   <= w_blk_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_DONE);
      r_we    <= (w_state_nxt == ST_WR0) || (w_state_nxt == ST_WR1);
      r_round <= ((r_state == ST_ROUND) && (w_state_nxt == ST_ROUND)) ? (r_round + 4'd1) : 4'd0;
      if (w_launch) begin
        r_decrypt     <= decrypt;
        r_cbc         <= cbc;
        r_count       <= eff_count(block_count);
        r_blocks_done <= '0;
        r_in_addr     <= '0;
        r_out_addr    <= '0;
      end else if ((r_state == ST_WR1) && (w_state_nxt != ST_IDLE)) begin
        r_blocks_done <= r_blocks_done + MAX_BLK_W'(1);
      end
      if (w_state_nxt == ST_RD0) begin
        r_in_addr <= {w_blk_nxt, 1'b0};
      end else if (w_state_nxt == ST_RD1) begin
        r_in_addr <= {r_blk, 1'b1};
      end
      if (r_state == ST_RD1) begin
        r_lo <= ram_in_dout;
      end
      if (w_form) begin
        r_des_in <= w_pre;
      end
      if (w_capture) begin
        r_result_hi <= w_result[BLOCK_W-1:WORD_W];
        r_out_addr  <= {r_blk, 1'b0};
        r_out_din   <= w_result[WORD_W-1:0];
      end else if ((r_state == ST_WR0) && (w_state_nxt == ST_WR1)) begin
        r_out_addr <= {r_blk, 1'b1};
        r_out_din  <= r_result_hi;
      end
    end
  end

  des_cbc_chain u_chain (
    .i_clk     (clk1),
    .i_rst_n   (reset_n),
    .i_load    (w_launch),
    .i_iv      (iv),
    .i_cbc     (r_cbc),
    .i_decrypt (r_decrypt),
    .i_form    (w_form),
    .i_blk_in  ({ram_in_dout, r_lo}),
    .o_des_in  (w_pre),
    .i_update  (w_capture),
    .i_des_out (des_out),
    .o_result  (w_result)
  );

  assign busy          = r_busy;
  assign done          = r_done;
  assign blocks_done   = r_blocks_done;
  assign ram_in_addr   = r_in_addr;
  assign ram_out_addr  = r_out_addr;
  assign ram_out_din   = r_out_din;
  assign ram_out_we    = r_we;
  assign des_in        = r_des_in;
  assign des_round_sel = r_round;
  assign des_decrypt   = r_decrypt;

endmodule

// File: tb/tb_des_block_seq.sv
// Self-checking bench for des_block_seq with behavioural RAMs, an invertible
// stand-in for the DES core, and a mode-level CBC/ECB reference model.
`timescale 1ns/1ps
module tb_des_block_seq;
  import des_seq_pkg::*;

  localparam int AW  = 5;
  localparam int BW  = 6;
  localparam int CAP = 16;
  localparam int NW  = 32;
  localparam logic [63:0] K1 = 64'h3C6E_F372_A54F_F53A;
  localparam logic [63:0] K2 = 64'h9E37_79B9_7F4A_7C15;

  logic          clk1 = 1'b0;
  logic          reset_n, start, abort, decrypt, cbc;
  logic [63:0]   iv;
  logic [BW-1:0] block_count;
  logic          busy, done;
  logic [BW-1:0] blocks_done;
  logic [AW-1:0] ram_in_addr, ram_out_addr;
  logic [31:0]   ram_in_dout, ram_out_din;
  logic          ram_out_we;
  logic [63:0]   des_in, des_out;
  logic [3:0]    des_round_sel;
  logic          des_decrypt;

  always #5 clk1 = ~clk1;

  des_block_seq #(.ADDR_W(AW), .MAX_BLK_W(BW)) dut (
    .clk1(clk1), .reset_n(reset_n), .start(start), .abort(abort),
    .decrypt(decrypt), .cbc(cbc), .iv(iv), .block_count(block_count),
    .busy(busy), .done(done), .blocks_done(blocks_done),
    .ram_in_addr(ram_in_addr), .ram_in_dout(ram_in_dout),
    .ram_out_addr(ram_out_addr), .ram_out_din(ram_out_din), .ram_out_we(ram_out_we),
    .des_in(des_in), .des_round_sel(des_round_sel), .des_decrypt(des_decrypt),
    .des_out(des_out)
  );

  // Invertible stand-in cipher: encrypt = rotl13(x^K1)+K2, decrypt is its inverse.
  function automatic logic [63:0] core_f(input logic [63:0] x, input logic dec);
    logic [63:0] t;
    if (!dec) begin
      t = x ^ K1;
      t = {t[50:0], t[63:51]};
      return t + K2;
    end else begin
      t = x - K2;
      t = {t[12:0], t[63:13]};
      return t ^ K1;
    end
  endfunction

  // Core result is only valid on the last round; garbage otherwise.
  assign des_out = (des_round_sel == 4'd15) ? core_f(des_in, des_decrypt)
                                            : ~core_f(des_in, des_decrypt);

  logic [31:0]   mem_in  [0:NW-1];
  logic [31:0]   mem_out [0:NW-1];
  int            wr_cnt;
  logic [AW-1:0] last_wr_addr;

  always @(posedge clk1) ram_in_dout <= mem_in[ram_in_addr];

  always @(posedge clk1) begin
    if (ram_out_we) begin
      mem_out[ram_out_addr] <= ram_out_din;
      last_wr_addr          <= ram_out_addr;
      wr_cnt                <= wr_cnt + 1;
    end
  end

  logic [127:0] w_outs;
  assign w_outs = {8'd0, busy, done, blocks_done, ram_in_addr, ram_out_addr, ram_out_din,
                   ram_out_we, des_in, des_round_sel, des_decrypt};

  int          n_checks;
  int          n_errors;
  logic [63:0] exp_blk [0:CAP-1];
  logic [63:0] orig    [0:CAP-1];
  logic [63:0] ecb_ref;
  logic [63:0] pt;
  int          snap;
  logic        rd, rc;
  logic [63:0] riv;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Textbook ECB/CBC over the blocks currently held in the input RAM.
  task automatic model(input logic dec, input logic cb, input logic [63:0] ivv, input int n);
    logic [63:0] ch, p, o;
    ch = ivv;
    for (int i = 0; i < n; i++) begin
      p = {mem_in[2*i+1], mem_in[2*i]};
      if (!cb) begin
        o = core_f(p, dec);
      end else if (!dec) begin
        o  = core_f(p ^ ch, 1'b0);
        ch = o;
      end else begin
        o  = core_f(p, 1'b1) ^ ch;
        ch = p;
      end
      exp_blk[i] = o;
    end
  endtask

  task automatic do_run(input string tag, input logic dec, input logic cb, input logic [63:0] ivv,
                        input int bc, input int abort_cyc, input int restart_cyc);
    int n_eff, n_exp, wr0, last_cyc, done_seen;
    logic [63:0] prev_in;
    logic ab, exp_we;
    n_eff    = (bc > CAP) ? CAP : bc;
    last_cyc = 21 * n_eff + 1;
    n_exp    = n_eff;
    if (abort_cyc > 0 && (abort_cyc / 21) < n_eff) n_exp = abort_cyc / 21;
    model(dec, cb, ivv, n_eff);
    @(negedge clk1);
    decrypt = dec; cbc = cb; iv = ivv; block_count = BW'(bc); start = 1'b1;
    wr0 = wr_cnt;
    @(posedge clk1); #1;
    start = 1'b0;
    decrypt = 1'($urandom); cbc = 1'($urandom); iv = {$urandom, $urandom};
    block_count = BW'($urandom);
    done_seen = 0;
    prev_in   = des_in;
    for (int cyc = 1; cyc <= last_cyc + 8; cyc++) begin
      ab = (abort_cyc > 0) && (cyc > abort_cyc);
      if (cyc == abort_cyc) abort = 1'b1;
      if (cyc == restart_cyc) begin
        start = 1'b1; block_count = BW'(1);
      end
      @(negedge clk1);
      exp_we = !ab && (cyc <= 21 * n_eff) && (((cyc - 1) % 21) >= 19);
      check({tag, ":busy"}, 128'(busy), 128'(!ab && cyc <= last_cyc));
      check({tag, ":done"}, 128'(done), 128'(!ab && abort_cyc <= 0 && cyc == last_cyc));
      check({tag, ":we"}, 128'(ram_out_we), 128'(exp_we));
      if (done === 1'b1) done_seen++;
      if (!ab && cyc <= last_cyc) check({tag, ":des_decrypt"}, 128'(des_decrypt), 128'(dec));
      if (des_round_sel != 4'd0) check({tag, ":des_in_stable"}, 128'(des_in), 128'(prev_in));
      prev_in = des_in;
      @(posedge clk1); #1;
      abort = 1'b0; start = 1'b0;
    end
    check({tag, ":done_pulses"}, 128'(done_seen), 128'((abort_cyc > 0) ? 0 : 1));
    check({tag, ":writes"}, 128'(wr_cnt - wr0), 128'(2 * n_exp));
    check({tag, ":blocks_done"}, 128'(blocks_done), 128'(n_exp));
    for (int i = 0; i < n_exp; i++)
      check({tag, ":data"}, 128'({mem_out[2*i+1], mem_out[2*i]}), 128'(exp_blk[i]));
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    reset_n = 1'b1; start = 1'b0; abort = 1'b0; decrypt = 1'b0; cbc = 1'b0;
    iv = 64'd0; block_count = '0;
    for (int i = 0; i < NW; i++) mem_in[i] = $urandom;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    check("reset_outs", w_outs, 128'd0);
    reset_n = 1'b1;

    // ECB encrypt, single block.
    pt = 64'h0123_4567_89AB_CDEF;
    mem_in[0] = pt[31:0]; mem_in[1] = pt[63:32];
    do_run("ecb1", 1'b0, 1'b0, 64'd0, 1, 0, 0);
    ecb_ref = {mem_out[1], mem_out[0]};

    // CBC encrypt of three identical blocks with zero iv.
    for (int i = 0; i < 3; i++) begin
      mem_in[2*i] = pt[31:0]; mem_in[2*i+1] = pt[63:32];
    end
    do_run("cbc_enc", 1'b0, 1'b1, 64'd0, 3, 0, 0);
    check("cbc_b0_eq_ecb", 128'({mem_out[1], mem_out[0]}), 128'(ecb_ref));
    check("cbc_b1_differs", 128'({mem_out[3], mem_out[2]} != ecb_ref), 128'd1);
    check("cbc_b2_differs", 128'({mem_out[5], mem_out[4]} != ecb_ref), 128'd1);

    // CBC decrypt of that ciphertext recovers the plaintext.
    for (int i = 0; i < 6; i++) mem_in[i] = mem_out[i];
    do_run("cbc_dec", 1'b1, 1'b1, 64'd0, 3, 0, 0);
    for (int i = 0; i < 3; i++)
      check("cbc_roundtrip", 128'({mem_out[2*i+1], mem_out[2*i]}), 128'(pt));

    // ECB encrypt/decrypt round trip on random data.
    for (int i = 0; i < 4; i++) begin
      orig[i] = {$urandom, $urandom};
      mem_in[2*i] = orig[i][31:0]; mem_in[2*i+1] = orig[i][63:32];
    end
    do_run("ecb_enc4", 1'b0, 1'b0, 64'd0, 4, 0, 0);
    for (int i = 0; i < 8; i++) mem_in[i] = mem_out[i];
    do_run("ecb_dec4", 1'b1, 1'b0, 64'd0, 4, 0, 0);
    for (int i = 0; i < 4; i++)
      check("ecb_roundtrip", 128'({mem_out[2*i+1], mem_out[2*i]}), 128'(orig[i]));

    // Random modes and counts; the first also pulses start while busy.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NW; i++) mem_in[i] = $urandom;
      rd = 1'($urandom); rc = 1'($urandom); riv = {$urandom, $urandom};
      do_run("rand", rd, rc, riv, $urandom_range(1, 5), 0, (r == 0) ? 7 : 0);
    end

    // Zero count: immediate done, no writes.
    do_run("zero", 1'b0, 1'b1, 64'd5, 0, 0, 0);

    // Count of 2^ADDR_W saturates to capacity.
    for (int i = 0; i < NW; i++) mem_in[i] = $urandom;
    do_run("sat", 1'b0, 1'b1, {$urandom, $urandom}, 32, 0, 0);
    check("sat_last_addr", 128'(last_wr_addr), 128'(NW - 1));

    // Abort in ROUND of the second of four blocks.
    do_run("abort", 1'b0, 1'b1, {$urandom, $urandom}, 4, 30, 0);

    // Start and abort together: nothing starts.
    @(negedge clk1);
    block_count = BW'(3); start = 1'b1; abort = 1'b1; snap = wr_cnt;
    @(posedge clk1); #1;
    start = 1'b0; abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk1);
      check("start_abort_busy", 128'(busy), 128'd0);
    end
    check("start_abort_writes", 128'(wr_cnt - snap), 128'd0);

    // Asynchronous reset in WR0 of the first block.
    @(negedge clk1);
    decrypt = 1'b1; cbc = 1'b1; iv = {$urandom, $urandom}; block_count = BW'(2);
    start = 1'b1; snap = wr_cnt;
    @(posedge clk1); #1;
    start = 1'b0;
    repeat (19) @(posedge clk1);
    @(negedge clk1);
    check("rst_we_before", 128'(ram_out_we), 128'd1);
    #1 reset_n = 1'b0;
    #1 check("rst_async_outs", w_outs, 128'd0);
    @(posedge clk1); #1;
    check("rst_no_write", 128'(wr_cnt - snap), 128'd0);
    @(negedge clk1);
    reset_n = 1'b1;
    do_run("post_reset", 1'b1, 1'b1, {$urandom, $urandom}, 2, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/des_block_seq.md
# des_block_seq

Parametrised block sequencer for the DES datapath. It walks a configurable number of 64-bit blocks out of an input block RAM and steps an external 16-round DES core on each block. Results go to an output block RAM. ECB and CBC are supported in both encrypt and decrypt directions. It sits between the pipe-side RAMs and the DES core, in the DES core's clock domain, and replaces the fixed full-RAM ECB sequencer.

## Interface
Parameters:
- ADDR_W, 9: word address width of the 32-bit RAM ports. Capacity is 2^(ADDR_W-1) blocks.
- MAX_BLK_W, ADDR_W: width of `block_count` and `blocks_done`.

Ports:
- clk1  in  1  sole clock; RAM B ports and the DES core use it too.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a run.
- abort  in  1  one-cycle pulse that cancels a run.
- decrypt  in  1  direction; latched at start.
- cbc  in  1  1 = CBC, 0 = ECB; latched at start.
- iv  in  64  CBC initial vector; latched at start.
- block_count  in  MAX_BLK_W  number of blocks to process; latched at start.
- busy  out  1  high from the cycle after start until DONE or IDLE is re-entered.
- done  out  1  one-cycle completion pulse.
- blocks_done  out  MAX_BLK_W  number of blocks fully written in the current or last run.
- ram_in_addr  out  ADDR_W  input RAM read address.
- ram_in_dout  in  32  input RAM read data; 1-cycle read latency.
- ram_out_addr  out  ADDR_W  output RAM write address.
- ram_out_din  out  32  output RAM write data.
- ram_out_we  out  1  output RAM write strobe.
- des_in  out  64  DES core input block.
- des_round_sel  out  4  DES core round select.
- des_decrypt  out  1  DES core direction; equals the latched `decrypt`.
- des_out  in  64  DES core result.

## Operation
- States: IDLE, RD0, RD1, RD2, ROUND, WR0, WR1, DONE.
- IDLE, on `start`:
  - latch mode, iv and count;
  - clear the address counters and `blocks_done`;
  - set chain register = iv.
  - If the effective count is 0, go to DONE; otherwise go to RD0.
- Effective count: `block_count` values above capacity saturate to 2^(ADDR_W-1).
- RD0: drive `ram_in_addr` = 2b (low word).
- RD1: drive `ram_in_addr` = 2b+1; capture the low word.
- RD2: capture the high word; form `des_in`; set `des_round_sel` = 0.
- ROUND: increment `des_round_sel` each cycle. At the edge where it equals 15, sample `des_out` into the result register and go to WR0.
- Block input and output by mode:
  - ECB: `des_in` = P; result = `des_out`.
  - CBC encrypt: `des_in` = P xor chain; result = `des_out`; chain = result.
  - CBC decrypt: `des_in` = C; result = `des_out` xor chain; chain = C (the raw input block).
- WR0: write result[31:0] at address 2b.
- WR1: write result[63:32] at address 2b+1; increment `blocks_done`. If `blocks_done` + 1 == count, go to DONE; otherwise increment b and go to RD0.
- DONE: `done` = 1 for one cycle, then go to IDLE.
- `start` while busy: ignored.
- `abort` in any non-IDLE state: the next state is IDLE; no `done` pulse; `ram_out_we` = 0 from the next cycle; `blocks_done` holds its value.
- `abort` and `start` in the same cycle: abort wins, so the run does not start.
- Address wrap: not possible, because the count saturates.

## Timing
- Reset values: all outputs 0, state IDLE, chain register 0.
- Reset is asynchronous mid-run: the run is lost and the RAM write strobe drops immediately.
- Block cost is 21 cycles: RD0–RD2 take 3, ROUND takes 16, WR0–WR1 take 2.
- Start sampled at edge 0 → `done` is high in cycle 21·N+1. With N=0, `done` is high in cycle 1.
- `busy` is high in cycles 1 .. 21·N+1.
- `ram_out_we` is high exactly 2 cycles per block, and never outside WR0/WR1.
- `des_in` is stable throughout ROUND.

## Structure
- Package `des_seq_pkg` holds:
  - the state enum;
  - the ROUNDS = 16 constant;
  - the WORD_W = 32 and BLOCK_W = 64 constants.
- Sub-module `des_cbc_chain` holds the chain register, the iv load, and the mode-dependent pre-XOR and post-XOR plus the chain update.
- The sequencer FSM, address counters and block counter live in `des_block_seq`.

## Test plan
- ECB encrypt, key 133457799BBCDFF1, one block 0123456789ABCDEF → output RAM words 0F0AB405, 85E81354 at addresses 0/1; `done` in cycle 22.
- CBC encrypt, iv 0, 3 identical blocks → block 0 equals the ECB result; blocks 1 and 2 differ from it and match the reference model; `blocks_done` = 3; `done` in cycle 64.
- CBC decrypt of the previous ciphertext with the same iv → recovers the plaintext bit-exactly; also ECB decrypt round-trip.
- block_count = 0 → `done` in cycle 1; no RAM writes. block_count = 2^ADDR_W → saturates, processes 2^(ADDR_W-1) blocks, last write at address 2^ADDR_W−1.
- `abort` in ROUND of block 2 (of 4) → IDLE next cycle; no `done`; `blocks_done` = 1; no further writes. Also `start` + `abort` in the same cycle → stays IDLE.
- `reset_n` low mid-WR0 → `ram_out_we` low asynchronously and all outputs 0; a restart afterwards succeeds. `start` while busy is ignored.
